// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift 8 data + odd parity + stop, check ack.
// Optional feature: define PS2_TX_RETRY_EN to retry a NACKed byte up to two more times.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkLow,
  output logic       ps2DataLow,
  output logic       txDone,
  output logic       txError
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_START = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic START_AT_ACCEPT = (INHIBIT_CYCLES == 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t          state_reg;
  logic [1:0]      clk_sync_reg;
  logic [1:0]      data_sync_reg;
  logic            clk_prev_reg;
  logic [CW-1:0]   cnt_reg;
  logic [8:0]      shift_reg;
  logic [3:0]      bit_reg;
  logic            fall_edge;

`ifdef PS2_TX_RETRY_EN
  logic [8:0]      frame_reg;
  logic [1:0]      retry_reg;
`endif

  assign fall_edge = clk_prev_reg & ~clk_sync_reg[1];

  // Synchronizers idle high so that reset release never looks like a clock fall.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2ClkIn};
      data_sync_reg <= {data_sync_reg[0], ps2DataIn};
      clk_prev_reg  <= clk_sync_reg[1];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      bit_reg    <= '0;
      txReady    <= 1'b0;
      ps2ClkLow  <= 1'b0;
      ps2DataLow <= 1'b0;
      txDone     <= 1'b0;
      txError    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      frame_reg  <= '0;
      retry_reg  <= '0;
`endif
    end else begin
      txDone  <= 1'b0;
      txError <= 1'b0;
      case (state_reg)
        IDLE: begin
          ps2ClkLow  <= 1'b0;
          ps2DataLow <= 1'b0;
          txReady    <= 1'b1;
          if (txValid && txReady) begin
            shift_reg  <= {~^txData, txData};
            bit_reg    <= '0;
            cnt_reg    <= '0;
            ps2ClkLow  <= 1'b1;
            ps2DataLow <= START_AT_ACCEPT;
            txReady    <= 1'b0;
            state_reg  <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
            frame_reg  <= {~^txData, txData};
            retry_reg  <= '0;
`endif
          end
        end

        INHIBIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == INH_START) ps2DataLow <= 1'b1;
          if (cnt_reg == INH_LAST) begin
            // Release the clock with the start bit already on the line; watchdog starts here.
            ps2ClkLow  <= 1'b0;
            ps2DataLow <= 1'b1;
            cnt_reg    <= '0;
            state_reg  <= REQ;
          end
        end

        REQ, SHIFT, ACK, WAIT_IDLE: begin
          if (cnt_reg == WD_LAST) begin
            // Watchdog expiry takes priority over any coincident clock fall.
            ps2ClkLow  <= 1'b0;
            ps2DataLow <= 1'b0;
            txError    <= 1'b1;
            txReady    <= 1'b1;
            state_reg  <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            case (state_reg)
              REQ: begin
                if (fall_edge) begin
                  ps2DataLow <= ~shift_reg[0];
                  shift_reg  <= {1'b0, shift_reg[8:1]};
                  bit_reg    <= 4'd1;
                  state_reg  <= SHIFT;
                end
              end
              SHIFT: begin
                if (fall_edge) begin
                  if (bit_reg == 4'd9) begin
                    ps2DataLow <= 1'b0;
                    state_reg  <= ACK;
                  end else begin
                    ps2DataLow <= ~shift_reg[0];
                    shift_reg  <= {1'b0, shift_reg[8:1]};
                    bit_reg    <= bit_reg + 1'b1;
                  end
                end
              end
              ACK: begin
                if (fall_edge) begin
                  if (!data_sync_reg[1]) begin
                    state_reg <= WAIT_IDLE;
                  end else begin
`ifdef PS2_TX_RETRY_EN
                    if (retry_reg != 2'd2) begin
                      retry_reg  <= retry_reg + 1'b1;
                      shift_reg  <= frame_reg;
                      bit_reg    <= '0;
                      cnt_reg    <= '0;
                      ps2ClkLow  <= 1'b1;
                      ps2DataLow <= START_AT_ACCEPT;
                      state_reg  <= INHIBIT;
                    end else begin
                      ps2DataLow <= 1'b0;
                      txError    <= 1'b1;
                      txReady    <= 1'b1;
                      state_reg  <= IDLE;
                    end
`else
                    ps2DataLow <= 1'b0;
                    txError    <= 1'b1;
                    txReady    <= 1'b1;
                    state_reg  <= IDLE;
`endif
                  end
                end
              end
              WAIT_IDLE: begin
                if (clk_sync_reg[1] && data_sync_reg[1]) begin
                  txDone    <= 1'b1;
                  txReady   <= 1'b1;
                  state_reg <= IDLE;
                end
              end
              default: state_reg <= IDLE;
            endcase
          end
        end

        default: begin
          ps2ClkLow  <= 1'b0;
          ps2DataLow <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural keyboard that clocks the frame and acks or NACKs.
module tb_ps2_host_tx;

  localparam int INH     = 300;
  localparam int TMO     = 3000;
  localparam int H       = 20;
  localparam int BUDGET  = 2000;
`ifdef PS2_TX_RETRY_EN
  localparam int NACK_ATTEMPTS = 3;
`else
  localparam int NACK_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] tb_data = 8'h00;
  logic [7:0] scr_data = 8'h00;
  logic       scramble = 1'b0;
  logic [7:0] txData;
  logic       txValid = 1'b0;
  logic       txReady;
  logic       ps2ClkIn, ps2DataIn;
  logic       ps2ClkLow, ps2DataLow;
  logic       txDone, txError;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, inh_starts = 0;
  logic prev_done = 1'b0, prev_err = 1'b0, prev_clklow = 1'b0;

  assign txData    = scramble ? scr_data : tb_data;
  assign ps2ClkIn  = ~ps2ClkLow & ~dev_clk_low;
  assign ps2DataIn = ~ps2DataLow & ~dev_data_low;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetN(resetN), .txData(txData), .txValid(txValid), .txReady(txReady),
    .ps2ClkIn(ps2ClkIn), .ps2DataIn(ps2DataIn), .ps2ClkLow(ps2ClkLow), .ps2DataLow(ps2DataLow),
    .txDone(txDone), .txError(txError)
  );

  always @(negedge clk) begin
    if (txDone) done_cnt <= done_cnt + 1;
    if (txError) err_cnt <= err_cnt + 1;
    if (txDone && txError) both_cnt <= both_cnt + 1;
    if ((txDone && prev_done) || (txError && prev_err)) wide_cnt <= wide_cnt + 1;
    if (ps2ClkLow && !prev_clklow) inh_starts <= inh_starts + 1;
    prev_done   <= txDone;
    prev_err    <= txError;
    prev_clklow <= ps2ClkLow;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (scramble) scr_data = 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    logic [10:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = ((ones % 2) == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic dev_xfer(input bit do_ack, input int n_rises,
                          output logic [10:0] bits, output int inh, output bit ok);
    int w;
    bits = '0;
    inh = 0;
    ok = 1'b1;
    w = 0;
    while (!ps2ClkLow && w < BUDGET) begin @(negedge clk); w++; end
    if (!ps2ClkLow) begin ok = 1'b0; return; end
    while (ps2ClkLow && inh < BUDGET) begin inh++; @(negedge clk); end
    if (ps2ClkLow) begin ok = 1'b0; return; end
    bits[0] = ps2DataIn;
    for (int i = 1; i <= n_rises; i++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      bits[i] = ps2DataIn;
      dev_clk_low = 1'b0;
    end
    if (n_rises < 10) return;
    repeat (H) @(negedge clk);
    dev_data_low = do_ack;
    repeat (4) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_pulse(input int d0, input int e0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic send_ack(input logic [7:0] b, input bit check_inh);
    logic [10:0] bits;
    int inh, d0, e0;
    bit ok;
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tb_data = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    check("ready_low_in_transfer", txReady, 0);
    dev_xfer(1'b1, 10, bits, inh, ok);
    check("dev_handshake", ok, 1);
    if (check_inh) check("inhibit_len", inh, INH);
    check("frame_bits", bits, frame_of(b));
    wait_pulse(d0, e0);
    check("done_count", done_cnt - d0, 1);
    check("error_count", err_cnt - e0, 0);
    $display("send byte=%02h line=%03h inhibit=%0d done=%0d err=%0d",
             b, bits, inh, done_cnt - d0, err_cnt - e0);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  b, a;
    int inh, n, d0, e0, s0;
    bit ok;

    repeat (3) @(negedge clk);
    check("reset_clklow", ps2ClkLow, 0);
    check("reset_datalow", ps2DataLow, 0);
    check("reset_done", txDone, 0);
    check("reset_error", txError, 0);
    resetN = 1'b1;
    @(negedge clk);
    check("ready_after_reset", txReady, 1);

    send_ack(8'hED, 1'b1);
    send_ack(8'h00, 1'b0);
    send_ack(8'hFF, 1'b0);
    send_ack(8'h01, 1'b0);
    for (int k = 0; k < 5; k++) send_ack(8'($urandom), 1'b1);

    // Device never clocks: watchdog must fire and release both lines.
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tb_data = 8'($urandom);
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    n = 0;
    while (ps2ClkLow && n < BUDGET) begin @(negedge clk); n++; end
    n = 0;
    while (!txError && n < TMO + 100) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TMO);
    check("timeout_clk_released", ps2ClkLow, 0);
    check("timeout_data_released", ps2DataLow, 0);
    repeat (5) @(negedge clk);
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_done_count", done_cnt - d0, 0);
    $display("timeout cycles=%0d err=%0d", n, err_cnt - e0);

    // Device NACKs every attempt.
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = inh_starts;
    @(negedge clk);
    tb_data = 8'($urandom);
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    for (int k = 0; k < NACK_ATTEMPTS; k++) begin
      dev_xfer(1'b0, 10, bits, inh, ok);
      check("nack_attempt_handshake", ok, 1);
    end
    wait_pulse(d0, e0);
    repeat (INH + 50) @(negedge clk);
    check("nack_err_count", err_cnt - e0, 1);
    check("nack_done_count", done_cnt - d0, 0);
    check("nack_inhibit_periods", inh_starts - s0, NACK_ATTEMPTS);
    check("nack_lines_idle", {ps2ClkLow, ps2DataLow}, 0);
    $display("nack attempts=%0d err=%0d", inh_starts - s0, err_cnt - e0);

    // Reset in the middle of SHIFT after bit 4 has been driven.
    d0 = done_cnt;
    e0 = err_cnt;
    b = 8'($urandom) & 8'hEF;
    @(negedge clk);
    tb_data = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    dev_xfer(1'b1, 5, bits, inh, ok);
    check("midreset_handshake", ok, 1);
    check("midreset_bits", bits[5:0], frame_of(b) & 11'h03F);
    @(negedge clk);
    check("midreset_bit4_driven", ps2DataLow, 1);
    #2 resetN = 1'b0;
    #1;
    check("midreset_clk_released", ps2ClkLow, 0);
    check("midreset_data_released", ps2DataLow, 0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check("midreset_ready", txReady, 1);
    repeat (50) @(negedge clk);
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_no_error", err_cnt - e0, 0);
    $display("midreset byte=%02h done=%0d err=%0d", b, done_cnt - d0, err_cnt - e0);

    // txValid held with txData changing: only the first byte goes out, next accept right after txDone.
    a = 8'($urandom);
    b = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    tb_data = a;
    txValid = 1'b1;
    @(negedge clk);
    scramble = 1'b1;
    dev_xfer(1'b1, 10, bits, inh, ok);
    check("hold_handshake", ok, 1);
    check("hold_first_frame", bits, frame_of(a));
    n = 0;
    while (!txDone && n < 300) begin @(negedge clk); n++; end
    check("hold_done_seen", txDone, 1);
    #1;
    scramble = 1'b0;
    tb_data = b;
    @(negedge clk);
    check("hold_next_accept", ps2ClkLow, 1);
    #1 txValid = 1'b0;
    dev_xfer(1'b1, 10, bits, inh, ok);
    check("hold_second_frame", bits, frame_of(b));
    wait_pulse(d0 + 1, e0);
    check("hold_done_count", done_cnt - d0, 2);
    check("hold_err_count", err_cnt - e0, 0);
    $display("hold first=%02h second=%02h done=%0d", a, b, done_cnt - d0);

    repeat (10) @(negedge clk);
    check("never_done_and_error", both_cnt, 0);
    check("pulses_one_cycle", wide_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
